// File: rtl/pipe_stage_seq_pkg.sv
// rtl/pipe_stage_seq_pkg.sv - shared widths, control-word bit positions and rom_addr layout
// The ROM image generator reads the same offsets, so keep the field order stable.
package jam_pipe_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int STEP_W_DEF    = 2;
  localparam int FLAG_W_DEF    = 7;
  localparam int CTRL_W_DEF    = 17;
  localparam int BREAK_BIT_DEF = 15;
  localparam int LAST_BIT_DEF  = 16;

  localparam logic [7:0] NOP_OP_DEF = 8'h00;

  // rom_addr = {instr, step, flags}; flags occupy the low bits
  localparam int ROM_FLAGS_LSB = 0;
  localparam int ROM_STEP_LSB  = ROM_FLAGS_LSB + FLAG_W_DEF;
  localparam int ROM_INSTR_LSB = ROM_STEP_LSB + STEP_W_DEF;
  localparam int ROM_ADDR_W    = ROM_INSTR_LSB + DATA_W_DEF;

  typedef enum logic [1:0] {
    CTR_HOLD  = 2'd0,
    CTR_CLEAR = 2'd1,
    CTR_INC   = 2'd2
  } ctr_op_e;

  function automatic int rom_step_lsb(input int flag_w);
    return flag_w;
  endfunction

  function automatic int rom_instr_lsb(input int flag_w, input int step_w);
    return flag_w + step_w;
  endfunction

endpackage

// File: rtl/pipe_stage_seq_if.sv
// rtl/pipe_stage_seq_if.sv - upstream opcode valid/ready handshake into the stage
// The previous stage is the master; pipe_stage_seq is the slave.
interface pipe_stage_seq_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] pipe_in;
  logic              pipe_in_valid;
  logic              pipe_in_ready;

  modport master (
    output pipe_in,
    output pipe_in_valid,
    input  pipe_in_ready
  );

  modport slave (
    input  pipe_in,
    input  pipe_in_valid,
    output pipe_in_ready
  );

endinterface

// File: rtl/pipe_stage_seq_step_ctr.sv
// rtl/pipe_stage_seq_step_ctr.sv - micro-step counter with clear/inc/hold
// terminal_o flags the final step so the stage can force retirement.
module pipe_step_ctr
  import jam_pipe_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  ctr_op_e           op_i,
  output logic [STEP_W-1:0] step_o,
  output logic              terminal_o
);

  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] step_d;

  always_comb begin
    step_d = step_q;
    case (op_i)
      CTR_CLEAR: step_d = '0;
      CTR_INC:   step_d = step_q + STEP_W'(1);
      default:   step_d = step_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end

  assign step_o     = step_q;
  assign terminal_o = &step_q;

endmodule

// File: rtl/pipe_stage_seq.sv
// rtl/pipe_stage_seq.sv - micro-stepped decode stage: opcode/step/flags -> ROM -> registered control word
// Handles stall, flush, break-halt and an upstream valid/ready handshake.
module pipe_stage_seq
  import jam_pipe_pkg::*;
#(
  parameter int              DATA_W    = DATA_W_DEF,
  parameter int              STEP_W    = STEP_W_DEF,
  parameter int              FLAG_W    = FLAG_W_DEF,
  parameter int              CTRL_W    = CTRL_W_DEF,
  parameter int              BREAK_BIT = BREAK_BIT_DEF,
  parameter int              LAST_BIT  = LAST_BIT_DEF,
  parameter logic [DATA_W-1:0] NOP_OP  = DATA_W'(NOP_OP_DEF)
) (
  input  logic                            clk,
  input  logic                            rst,
  pipe_stage_seq_if.slave                 up,
  input  logic [FLAG_W-1:0]               flags,
  input  logic                            stall,
  input  logic                            flush,
  input  logic                            resume,
  output logic [DATA_W+STEP_W+FLAG_W-1:0] rom_addr,
  input  logic [CTRL_W-1:0]               rom_data,
  output logic [CTRL_W-2:0]               ctrl_out,
  output logic                            ctrl_valid,
  output logic [DATA_W-1:0]               pipe_out,
  output logic [STEP_W-1:0]               step_out,
  output logic                            halted
);

  logic [DATA_W-1:0] instr_q,      instr_d;
  logic              valid_q,      valid_d;
  logic              halted_q,     halted_d;
  logic [CTRL_W-2:0] ctrl_q,       ctrl_d;
  logic              ctrl_valid_q, ctrl_valid_d;
  logic [DATA_W-1:0] pipe_out_q,   pipe_out_d;
  logic [STEP_W-1:0] step_out_q,   step_out_d;

  ctr_op_e           ctr_op;
  logic [STEP_W-1:0] step_q;
  logic              step_terminal;
  logic              last_now;
  logic [CTRL_W-2:0] ctrl_word;

  pipe_step_ctr #(
    .STEP_W (STEP_W)
  ) u_step_ctr (
    .clk        (clk),
    .rst        (rst),
    .op_i       (ctr_op),
    .step_o     (step_q),
    .terminal_o (step_terminal)
  );

  // Control word is rom_data with the LAST bit squeezed out
  for (genvar g = 0; g < CTRL_W - 1; g++) begin : g_strip_last
    assign ctrl_word[g] = rom_data[(g < LAST_BIT) ? g : g + 1];
  end

  assign rom_addr = {instr_q, step_q, flags};
  assign last_now = rom_data[LAST_BIT] | step_terminal;

  assign up.pipe_in_ready = !rst && !flush && !stall && !halted_q && (!valid_q || last_now);

  always_comb begin
    instr_d      = instr_q;
    valid_d      = valid_q;
    halted_d     = halted_q;
    ctrl_d       = ctrl_q;
    ctrl_valid_d = ctrl_valid_q;
    pipe_out_d   = pipe_out_q;
    step_out_d   = step_out_q;
    ctr_op       = CTR_HOLD;

    if (flush) begin
      instr_d      = NOP_OP;
      valid_d      = 1'b0;
      ctrl_d       = '0;
      ctrl_valid_d = 1'b0;
      pipe_out_d   = NOP_OP;
      step_out_d   = '0;
      ctr_op       = CTR_CLEAR;
    end else if (stall) begin
      ctr_op = CTR_HOLD;
    end else if (halted_q) begin
      ctrl_d       = '0;
      ctrl_valid_d = 1'b0;
      if (resume) begin
        halted_d = 1'b0;
      end
    end else if (valid_q) begin
      ctrl_d       = ctrl_word;
      ctrl_valid_d = 1'b1;
      pipe_out_d   = instr_q;
      step_out_d   = step_q;
      if (last_now) begin
        ctr_op = CTR_CLEAR;
        if (up.pipe_in_valid) begin
          instr_d = up.pipe_in;
        end else begin
          valid_d = 1'b0;
        end
      end else begin
        ctr_op = CTR_INC;
      end
      // The break word still issues; the halt bites from the next edge
      if (rom_data[BREAK_BIT]) begin
        halted_d = 1'b1;
      end
    end else begin
      ctrl_d       = '0;
      ctrl_valid_d = 1'b0;
      if (up.pipe_in_valid) begin
        instr_d = up.pipe_in;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q      <= NOP_OP;
      valid_q      <= 1'b0;
      halted_q     <= 1'b0;
      ctrl_q       <= '0;
      ctrl_valid_q <= 1'b0;
      pipe_out_q   <= NOP_OP;
      step_out_q   <= '0;
    end else begin
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      halted_q     <= halted_d;
      ctrl_q       <= ctrl_d;
      ctrl_valid_q <= ctrl_valid_d;
      pipe_out_q   <= pipe_out_d;
      step_out_q   <= step_out_d;
    end
  end

  assign ctrl_out   = ctrl_q;
  assign ctrl_valid = ctrl_valid_q;
  assign pipe_out   = pipe_out_q;
  assign step_out   = step_out_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_pipe_stage_seq.sv
// tb/tb_pipe_stage_seq.sv - directed self-checking bench for pipe_stage_seq
// ROM model: low 15 bits = {opcode, flags[4:0], step}; bit 15 break, bit 16 last.
module tb_pipe_stage_seq;

  logic        clk;
  logic        rst;
  logic [6:0]  flags;
  logic        stall;
  logic        flush;
  logic        resume;
  logic [16:0] rom_addr;
  logic [16:0] rom_data;
  logic [15:0] ctrl_out;
  logic        ctrl_valid;
  logic [7:0]  pipe_out;
  logic [1:0]  step_out;
  logic        halted;

  int n_chk;
  int n_fail;

  pipe_stage_seq_if #(.DATA_W(8)) up_if ();

  pipe_stage_seq dut (
    .clk        (clk),
    .rst        (rst),
    .up         (up_if),
    .flags      (flags),
    .stall      (stall),
    .flush      (flush),
    .resume     (resume),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .ctrl_out   (ctrl_out),
    .ctrl_valid (ctrl_valid),
    .pipe_out   (pipe_out),
    .step_out   (step_out),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rom_op;
  logic [1:0] rom_st;
  logic [6:0] rom_fl;
  logic [4:0] rom_fl5;

  always_comb begin
    rom_op  = rom_addr[16:9];
    rom_st  = rom_addr[8:7];
    rom_fl  = rom_addr[6:0];
    rom_fl5 = rom_fl[4:0] ^ {rom_fl[6:5], 3'b000};
    rom_data = {1'b0, 1'b0, rom_op, rom_fl5, rom_st};
    case (rom_op)
      8'h12: rom_data[16] = (rom_st == 2'd2);
      8'h55: begin
        rom_data[15] = (rom_st == 2'd0);
        rom_data[16] = (rom_st == 2'd1);
      end
      8'h77: rom_data[16] = 1'b0;
      default: rom_data[16] = 1'b1;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; up_if.pipe_in = 8'hAA; up_if.pipe_in_valid = 1'b1;
    flags = 7'h00; stall = 1'b0; flush = 1'b0; resume = 1'b0;
    tick(); tick();
    n_chk++; if (ctrl_valid !== 1'b0) begin n_fail++; $display("FAIL reset ctrl_valid: got %b want 0", ctrl_valid); end
    n_chk++; if (ctrl_out !== 16'h0000) begin n_fail++; $display("FAIL reset ctrl_out: got %h want 0000", ctrl_out); end
    n_chk++; if (pipe_out !== 8'h00) begin n_fail++; $display("FAIL reset pipe_out: got %h want 00", pipe_out); end
    n_chk++; if (step_out !== 2'd0) begin n_fail++; $display("FAIL reset step_out: got %0d want 0", step_out); end
    n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset halted: got %b want 0", halted); end
    n_chk++; if (up_if.pipe_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset ready: got %b want 0", up_if.pipe_in_ready); end
    n_chk++; if (rom_addr !== 17'h00000) begin n_fail++; $display("FAIL reset rom_addr: got %h want 00000", rom_addr); end
    rst = 1'b0; up_if.pipe_in_valid = 1'b0;
    #1;
    n_chk++; if (up_if.pipe_in_ready !== 1'b1) begin n_fail++; $display("FAIL post-reset ready: got %b want 1", up_if.pipe_in_ready); end
  endtask

  task automatic test_back_to_back();
    up_if.pipe_in = 8'h12; up_if.pipe_in_valid = 1'b1; flags = 7'h05;
    #1;
    n_chk++; if (up_if.pipe_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b idle ready: got %b want 1", up_if.pipe_in_ready); end
    tick();
    n_chk++; if (ctrl_valid !== 1'b0) begin n_fail++; $display("FAIL b2b accept bubble: got %b want 0", ctrl_valid); end
    n_chk++; if (rom_addr !== {8'h12, 2'd0, 7'h05}) begin n_fail++; $display("FAIL b2b rom_addr s0: got %h want %h", rom_addr, {8'h12, 2'd0, 7'h05}); end
    up_if.pipe_in = 8'h34;
    #1;
    n_chk++; if (up_if.pipe_in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b mid ready: got %b want 0", up_if.pipe_in_ready); end
    tick();
    n_chk++; if ({ctrl_valid, pipe_out, step_out, ctrl_out} !== {1'b1, 8'h12, 2'd0, 1'b0, 8'h12, 5'h05, 2'd0}) begin
      n_fail++; $display("FAIL b2b step0: got v=%b op=%h st=%0d ctrl=%h", ctrl_valid, pipe_out, step_out, ctrl_out); end
    n_chk++; if (rom_addr[8:7] !== 2'd1) begin n_fail++; $display("FAIL b2b rom step1: got %0d want 1", rom_addr[8:7]); end
    flags = 7'h0A;
    tick();
    n_chk++; if ({ctrl_valid, pipe_out, step_out, ctrl_out} !== {1'b1, 8'h12, 2'd1, 1'b0, 8'h12, 5'h0A, 2'd1}) begin
      n_fail++; $display("FAIL b2b step1: got v=%b op=%h st=%0d ctrl=%h", ctrl_valid, pipe_out, step_out, ctrl_out); end
    n_chk++; if (up_if.pipe_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b last ready: got %b want 1", up_if.pipe_in_ready); end
    tick();
    n_chk++; if ({ctrl_valid, pipe_out, step_out, ctrl_out} !== {1'b1, 8'h12, 2'd2, 1'b0, 8'h12, 5'h0A, 2'd2}) begin
      n_fail++; $display("FAIL b2b step2: got v=%b op=%h st=%0d ctrl=%h", ctrl_valid, pipe_out, step_out, ctrl_out); end
    n_chk++; if (rom_addr !== {8'h34, 2'd0, 7'h0A}) begin n_fail++; $display("FAIL b2b rom next: got %h want %h", rom_addr, {8'h34, 2'd0, 7'h0A}); end
    up_if.pipe_in_valid = 1'b0;
    tick();
    n_chk++; if ({ctrl_valid, pipe_out, step_out, ctrl_out} !== {1'b1, 8'h34, 2'd0, 1'b0, 8'h34, 5'h0A, 2'd0}) begin
      n_fail++; $display("FAIL b2b op34: got v=%b op=%h st=%0d ctrl=%h", ctrl_valid, pipe_out, step_out, ctrl_out); end
    tick();
    n_chk++; if (ctrl_valid !== 1'b0) begin n_fail++; $display("FAIL b2b drain: got %b want 0", ctrl_valid); end
    flags = 7'h00;
  endtask

  task automatic test_stall();
    up_if.pipe_in = 8'h12; up_if.pipe_in_valid = 1'b1;
    tick();
    up_if.pipe_in_valid = 1'b0;
    tick();
    tick();
    n_chk++; if (step_out !== 2'd1) begin n_fail++; $display("FAIL stall pre step: got %0d want 1", step_out); end
    stall = 1'b1;
    #1;
    n_chk++; if (up_if.pipe_in_ready !== 1'b0) begin n_fail++; $display("FAIL stall ready: got %b want 0", up_if.pipe_in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if ({ctrl_valid, step_out, ctrl_out} !== {1'b1, 2'd1, 1'b0, 8'h12, 5'h00, 2'd1}) begin
        n_fail++; $display("FAIL stall hold %0d: got v=%b st=%0d ctrl=%h", i, ctrl_valid, step_out, ctrl_out); end
    end
    stall = 1'b0;
    tick();
    n_chk++; if ({ctrl_valid, step_out, ctrl_out} !== {1'b1, 2'd2, 1'b0, 8'h12, 5'h00, 2'd2}) begin
      n_fail++; $display("FAIL stall step2: got v=%b st=%0d ctrl=%h", ctrl_valid, step_out, ctrl_out); end
    tick();
    n_chk++; if (ctrl_valid !== 1'b0) begin n_fail++; $display("FAIL stall drain: got %b want 0", ctrl_valid); end
  endtask

  task automatic test_flush();
    up_if.pipe_in = 8'h12; up_if.pipe_in_valid = 1'b1;
    tick();
    up_if.pipe_in_valid = 1'b0;
    tick();
    flush = 1'b1; up_if.pipe_in = 8'h34; up_if.pipe_in_valid = 1'b1;
    #1;
    n_chk++; if (up_if.pipe_in_ready !== 1'b0) begin n_fail++; $display("FAIL flush ready: got %b want 0", up_if.pipe_in_ready); end
    tick();
    n_chk++; if ({ctrl_valid, pipe_out, step_out, ctrl_out} !== {1'b0, 8'h00, 2'd0, 16'h0000}) begin
      n_fail++; $display("FAIL flush outputs: got v=%b op=%h st=%0d ctrl=%h", ctrl_valid, pipe_out, step_out, ctrl_out); end
    n_chk++; if (rom_addr[16:7] !== {8'h00, 2'd0}) begin n_fail++; $display("FAIL flush not consumed: got %h want 000", rom_addr[16:7]); end
    flush = 1'b0;
    #1;
    n_chk++; if (up_if.pipe_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush after ready: got %b want 1", up_if.pipe_in_ready); end
    tick();
    n_chk++; if (rom_addr[16:9] !== 8'h34) begin n_fail++; $display("FAIL flush accept: got %h want 34", rom_addr[16:9]); end
    up_if.pipe_in_valid = 1'b0;
    tick();
    n_chk++; if ({ctrl_valid, pipe_out, step_out} !== {1'b1, 8'h34, 2'd0}) begin
      n_fail++; $display("FAIL flush op34: got v=%b op=%h st=%0d", ctrl_valid, pipe_out, step_out); end
    tick();
  endtask

  task automatic test_break();
    up_if.pipe_in = 8'h55; up_if.pipe_in_valid = 1'b1;
    tick();
    up_if.pipe_in_valid = 1'b0;
    tick();
    n_chk++; if ({halted, ctrl_valid, ctrl_out} !== {1'b1, 1'b1, 1'b1, 8'h55, 5'h00, 2'd0}) begin
      n_fail++; $display("FAIL break word: got h=%b v=%b ctrl=%h", halted, ctrl_valid, ctrl_out); end
    n_chk++; if (up_if.pipe_in_ready !== 1'b0) begin n_fail++; $display("FAIL break ready: got %b want 0", up_if.pipe_in_ready); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_chk++; if ({halted, ctrl_valid, ctrl_out} !== {1'b1, 1'b0, 16'h0000}) begin
        n_fail++; $display("FAIL break bubble %0d: got h=%b v=%b ctrl=%h", i, halted, ctrl_valid, ctrl_out); end
    end
    resume = 1'b1;
    tick();
    n_chk++; if ({halted, ctrl_valid} !== 2'b00) begin n_fail++; $display("FAIL break resume: got h=%b v=%b want 00", halted, ctrl_valid); end
    resume = 1'b0;
    tick();
    n_chk++; if ({halted, ctrl_valid, step_out, ctrl_out} !== {1'b0, 1'b1, 2'd1, 1'b0, 8'h55, 5'h00, 2'd1}) begin
      n_fail++; $display("FAIL break step1: got h=%b v=%b st=%0d ctrl=%h", halted, ctrl_valid, step_out, ctrl_out); end
    tick();
    n_chk++; if (ctrl_valid !== 1'b0) begin n_fail++; $display("FAIL break drain: got %b want 0", ctrl_valid); end
  endtask

  task automatic test_forced_retire();
    up_if.pipe_in = 8'h77; up_if.pipe_in_valid = 1'b1;
    tick();
    up_if.pipe_in = 8'h34;
    for (int s = 0; s < 3; s++) begin
      tick();
      n_chk++; if ({ctrl_valid, pipe_out, step_out} !== {1'b1, 8'h77, 2'(s)}) begin
        n_fail++; $display("FAIL forced step%0d: got v=%b op=%h st=%0d", s, ctrl_valid, pipe_out, step_out); end
    end
    n_chk++; if (up_if.pipe_in_ready !== 1'b1) begin n_fail++; $display("FAIL forced ready: got %b want 1", up_if.pipe_in_ready); end
    tick();
    n_chk++; if ({ctrl_valid, step_out, ctrl_out} !== {1'b1, 2'd3, 1'b0, 8'h77, 5'h00, 2'd3}) begin
      n_fail++; $display("FAIL forced step3: got v=%b st=%0d ctrl=%h", ctrl_valid, step_out, ctrl_out); end
    n_chk++; if (rom_addr[16:7] !== {8'h34, 2'd0}) begin n_fail++; $display("FAIL forced next: got %h want %h", rom_addr[16:7], {8'h34, 2'd0}); end
    up_if.pipe_in_valid = 1'b0;
    tick();
    n_chk++; if ({ctrl_valid, pipe_out, step_out} !== {1'b1, 8'h34, 2'd0}) begin
      n_fail++; $display("FAIL forced op34: got v=%b op=%h st=%0d", ctrl_valid, pipe_out, step_out); end
    tick();
  endtask

  task automatic test_reset_mid();
    up_if.pipe_in = 8'h12; up_if.pipe_in_valid = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_chk++; if (up_if.pipe_in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst ready: got %b want 0", up_if.pipe_in_ready); end
    tick();
    n_chk++; if ({ctrl_valid, pipe_out, step_out, rom_addr[16:7]} !== {1'b0, 8'h00, 2'd0, 10'h000}) begin
      n_fail++; $display("FAIL midrst state: got v=%b op=%h st=%0d ra=%h", ctrl_valid, pipe_out, step_out, rom_addr); end
    rst = 1'b0; up_if.pipe_in_valid = 1'b0;
    tick();
    n_chk++; if (ctrl_valid !== 1'b0) begin n_fail++; $display("FAIL midrst idle: got %b want 0", ctrl_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_flush();
    test_break();
    test_forced_retire();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_seq.md
# pipe_stage_seq

Parametrised successor to the fixed pipeline stage-2 decoder of the JAM-1 pipelined CPU. It holds one instruction byte per stage and steps it through up to 2^STEP_W micro-steps. Each step forms an external decode-ROM address from {opcode, step, flags} and registers the returned control word as the stage's control outputs. It adds stall/flush/break handling and an upstream valid/ready handshake, so multi-cycle instructions and bus waits no longer need external glue.

## Interface
Parameters:
- DATA_W, 8: opcode/pipe byte width
- STEP_W, 2: micro-step counter width; MAX_STEPS = 2^STEP_W
- FLAG_W, 7: flag vector width (overflow, sign, zero, carryA, carryL, PCRA flip, reset)
- CTRL_W, 17: decode-ROM data width
- BREAK_BIT, 15: ROM data bit meaning "break"
- LAST_BIT, 16: ROM data bit meaning "last step of instruction"
- NOP_OP, 8'h00: opcode loaded on reset/flush

Ports (name, direction, width, meaning):
- clk, in, 1: clock, all state on rising edge
- rst, in, 1: synchronous, active-high reset
- pipe_in, in, DATA_W: opcode from previous stage
- pipe_in_valid, in, 1: pipe_in holds an instruction
- pipe_in_ready, out, 1: stage accepts pipe_in this cycle (combinational)
- flags, in, FLAG_W: ALU/status flags, sampled into ROM address
- stall, in, 1: freeze the stage (bus request wait / downstream hold)
- flush, in, 1: discard the held instruction
- resume, in, 1: leave break-halt
- rom_addr, out, DATA_W+STEP_W+FLAG_W: {instr_q, step_q, flags}, combinational
- rom_data, in, CTRL_W: asynchronous decode-ROM read data
- ctrl_out, out, CTRL_W-1: registered control word (rom_data without LAST_BIT); bit BREAK_BIT maps to the Break output
- ctrl_valid, out, 1: ctrl_out is a real step, not a bubble
- pipe_out, out, DATA_W: opcode that accompanies ctrl_out, passed to the next stage
- step_out, out, STEP_W: step index of ctrl_out
- halted, out, 1: stage is in break-halt

## Operation
- State: instr_q, valid_q, step_q, halted_q, plus output registers ctrl_q, ctrl_valid_q, pipe_out_q, step_out_q.
- last_now = rom_data[LAST_BIT] | (step_q == MAX_STEPS-1). A forced end at MAX_STEPS-1 is legal and not an error.
- Per-edge priority: rst > flush > stall > halted > normal.
- rst: instr_q=NOP_OP, valid_q=0, step_q=0, halted_q=0, ctrl_q=0, ctrl_valid_q=0, pipe_out_q=NOP_OP, step_out_q=0.
- flush: same values as rst except halted_q holds. The incoming pipe_in is not accepted that cycle.
- stall (no flush): every register holds; ctrl_out repeats its previous value.
- halted (no stall/flush): ctrl_q=0, ctrl_valid_q=0, nothing advances. resume clears halted_q; the next edge resumes normally.
- Normal, valid_q=1: ctrl_q=rom_data minus LAST_BIT, ctrl_valid_q=1, pipe_out_q=instr_q, step_out_q=step_q.
  - If last_now: step_q=0 and the instruction retires. If pipe_in_valid, load instr_q=pipe_in; otherwise valid_q=0.
  - Otherwise step_q+1.
  - If rom_data[BREAK_BIT]: halted_q=1, effective from the following edge. The break word itself is issued.
- Normal, valid_q=0: ctrl_q=0, ctrl_valid_q=0. Load pipe_in when pipe_in_valid.
- pipe_in_ready = !rst & !flush & !stall & !halted_q & (!valid_q | last_now).

## Timing
- Accept at edge k: the first control word (step 0) appears after edge k+1. An N-step instruction yields words after edges k+1..k+N.
- Back-to-back issue: the next instruction is accepted on the edge that issues the current last step, so there are no bubbles.
- flags are sampled each step via rom_addr, so conditional steps see flags live in that cycle.
- Stall of S cycles adds exactly S cycles; no step is lost or duplicated.
- Reset mid-instruction: the next edge yields the reset values, and pipe_in_ready is 0 during rst.

## Structure
- Package jam_pipe_pkg holds: default widths, NOP_OP, BREAK_BIT/LAST_BIT, and the rom_addr field offsets, which the ROM image generator shares.
- Sub-module pipe_step_ctr: step counter with clear/inc/hold and the MAX_STEPS wrap/terminal flag.

## Test plan
- Reset: assert rst 2 cycles with pipe_in_valid=1 → all outputs at reset values, pipe_in_ready=0, ctrl_valid=0.
- 3-step opcode 8'h12 (LAST_BIT set at step 2) followed by 8'h34 (1-step) → step_out 0,1,2,0 on consecutive cycles, pipe_out 12,12,12,34, no bubble; rom_addr step field tracks.
- Stall 3 cycles during step 1 of 8'h12 → ctrl_out/step_out held 3 cycles, then step 2; total 6 issue cycles.
- Flush during step 1 with pipe_in_valid=1 → next cycle ctrl_valid=0, pipe_out=8'h00, pipe_in not consumed; it is accepted the following cycle.
- Break word (bit 15) at step 0 of 8'h55 → word issued with bit 15=1, halted=1, bubbles until resume pulse, then step 1 issues.
- ROM never sets LAST_BIT, STEP_W=2 → forced retire after step 3; next opcode accepted on that edge.
